// File: rtl/uart_frame_codec.sv
// Framed-string UART endpoint: wraps payloads as DELIM DELIM payload DELIM DELIM on TX,
// and hunts, validates and publishes framed payloads on RX. Includes the byte-level cores.

module uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shifter;
  logic          active;

  // done pulses once the stop bit has been on the line for a full bit period
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      active   <= 1'b0;
      tx       <= 1'b1;
      done     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shifter  <= '1;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (start) begin
          active   <= 1'b1;
          tx       <= 1'b0;
          shifter  <= {1'b1, data};
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      end else if (baud_cnt == CW'(CLKS_PER_BIT - 1)) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          active <= 1'b0;
          done   <= 1'b1;
        end else begin
          tx      <= shifter[0];
          shifter <= {1'b1, shifter[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end
    end
  end
endmodule

module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       vld
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  logic [1:0]    sync;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic          active;

  // Half a bit to the middle of the start bit, then whole bits; a bad stop bit drops the byte
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync     <= 2'b11;
      data     <= '0;
      vld      <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      active   <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      vld  <= 1'b0;
      if (!active) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
        if (!sync[1]) active <= 1'b1;
      end else if (baud_cnt == ((bit_cnt == 4'd0) ? CW'(CLKS_PER_BIT / 2 - 1)
                                                  : CW'(CLKS_PER_BIT - 1))) begin
        baud_cnt <= '0;
        bit_cnt  <= bit_cnt + 4'd1;
        if (bit_cnt == 4'd0) begin
          if (sync[1]) active <= 1'b0;
        end else if (bit_cnt == 4'd9) begin
          active <= 1'b0;
          vld    <= sync[1];
        end else begin
          data <= {sync[1], data[7:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end
    end
  end
endmodule

module uart_frame_codec #(
  parameter int         BAUD_RATE      = 115_200,
  parameter int         MAX_LEN        = 64,
  parameter logic [7:0] DELIM          = 8'h26,
  parameter int         RX_TIMEOUT_CLK = 500_000,
  parameter int         CLK_FREQ       = 50_000_000,
  localparam int        LEN_W          = 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [8*MAX_LEN-1:0]   tx_string,
  input  logic [LEN_W-1:0]       tx_length,
  input  logic                   tx_req,
  output logic                   tx_busy,
  output logic                   tx_done,
  output logic [8*MAX_LEN-1:0]   rx_string,
  output logic [LEN_W-1:0]       rx_length,
  output logic                   rx_busy,
  output logic                   rx_done,
  output logic                   rx_err,
  input  logic                   uart_rx_port,
  output logic                   uart_tx_port
);
  localparam int CPB   = CLK_FREQ / BAUD_RATE;
  localparam int TMR_W = $clog2(RX_TIMEOUT_CLK + 1);

  typedef enum logic [1:0] {T_IDLE, T_HEAD, T_BODY, T_TAIL} tx_state_t;
  typedef enum logic [1:0] {R_HUNT, R_HEAD, R_BODY, R_PEND} rx_state_t;

  tx_state_t            tx_state;
  logic [8*MAX_LEN-1:0] tx_buf;
  logic [LEN_W-1:0]     tx_len, tx_idx;
  logic                 byte_start, byte_done;
  logic [7:0]           byte_out;

  rx_state_t            rx_state;
  logic [8*MAX_LEN-1:0] shadow;
  logic [LEN_W-1:0]     cnt;
  logic [TMR_W-1:0]     timer;
  logic [7:0]           rx_byte;
  logic                 rx_vld;

  uart_tx #(.CLKS_PER_BIT(CPB)) u_tx (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(byte_start), .data(byte_out),
    .tx(uart_tx_port), .done(byte_done)
  );

  uart_rx #(.CLKS_PER_BIT(CPB)) u_rx (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(uart_rx_port), .data(rx_byte), .vld(rx_vld)
  );

  // The core latches its byte on the start pulse, so the mux only has to be valid then
  always_comb begin
    byte_out = DELIM;
    if (tx_state == T_BODY)
      for (int i = 0; i < MAX_LEN; i++)
        if (tx_idx == LEN_W'(i)) byte_out = tx_buf[8*i +: 8];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_state   <= T_IDLE;
      tx_buf     <= '0;
      tx_len     <= '0;
      tx_idx     <= '0;
      byte_start <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      byte_start <= 1'b0;
      tx_done    <= 1'b0;
      case (tx_state)
        T_IDLE: if (tx_req) begin
          tx_buf     <= tx_string;
          tx_len     <= (tx_length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : tx_length;
          tx_idx     <= '0;
          byte_start <= 1'b1;
          tx_busy    <= 1'b1;
          tx_state   <= T_HEAD;
        end
        T_HEAD: if (byte_done) begin
          byte_start <= 1'b1;
          if (tx_idx == LEN_W'(0)) begin
            tx_idx <= LEN_W'(1);
          end else begin
            tx_idx   <= '0;
            tx_state <= (tx_len == LEN_W'(0)) ? T_TAIL : T_BODY;
          end
        end
        T_BODY: if (byte_done) begin
          byte_start <= 1'b1;
          if (tx_idx == tx_len - LEN_W'(1)) begin
            tx_idx   <= '0;
            tx_state <= T_TAIL;
          end else begin
            tx_idx <= tx_idx + LEN_W'(1);
          end
        end
        T_TAIL: if (byte_done) begin
          if (tx_idx == LEN_W'(0)) begin
            tx_idx     <= LEN_W'(1);
            byte_start <= 1'b1;
          end else begin
            tx_state <= T_IDLE;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b1;
          end
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  // A DELIM inside the body is held in R_PEND until the next byte shows whether it closes the frame
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_state  <= R_HUNT;
      shadow    <= '0;
      cnt       <= '0;
      timer     <= '0;
      rx_string <= '0;
      rx_length <= '0;
      rx_busy   <= 1'b0;
      rx_done   <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      rx_err  <= 1'b0;
      if (rx_vld) timer <= TMR_W'(1);
      else if (rx_busy) timer <= timer + TMR_W'(1);
      case (rx_state)
        R_HUNT: if (rx_vld && rx_byte == DELIM) rx_state <= R_HEAD;
        R_HEAD: if (rx_vld) begin
          if (rx_byte == DELIM) begin
            rx_state <= R_BODY;
            cnt      <= '0;
            rx_busy  <= 1'b1;
          end else begin
            rx_state <= R_HUNT;
          end
        end
        R_BODY, R_PEND: if (rx_vld) begin
          if (rx_state == R_BODY && rx_byte == DELIM) begin
            rx_state <= R_PEND;
          end else if (rx_byte == DELIM) begin
            rx_string <= shadow;
            rx_length <= cnt;
            rx_done   <= 1'b1;
            rx_busy   <= 1'b0;
            rx_state  <= R_HUNT;
          end else if ((rx_state == R_BODY && cnt == LEN_W'(MAX_LEN)) ||
                       (rx_state == R_PEND && cnt >= LEN_W'(MAX_LEN - 1))) begin
            rx_err   <= 1'b1;
            rx_busy  <= 1'b0;
            rx_state <= R_HUNT;
          end else if (rx_state == R_BODY) begin
            for (int i = 0; i < MAX_LEN; i++)
              if (cnt == LEN_W'(i)) shadow[8*i +: 8] <= rx_byte;
            cnt <= cnt + LEN_W'(1);
          end else begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (cnt == LEN_W'(i)) shadow[8*i +: 8] <= DELIM;
              if (cnt + LEN_W'(1) == LEN_W'(i)) shadow[8*i +: 8] <= rx_byte;
            end
            cnt      <= cnt + LEN_W'(2);
            rx_state <= R_BODY;
          end
        end else if (timer == TMR_W'(RX_TIMEOUT_CLK - 1)) begin
          rx_err   <= 1'b1;
          rx_busy  <= 1'b0;
          rx_state <= R_HUNT;
        end
        default: rx_state <= R_HUNT;
      endcase
    end
  end
endmodule
